load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit with an in-order store queue, store-to-load forwarding and
// opportunistic draining of the oldest store to data memory.
module load_store_unit #(
  parameter int SQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [9:0]  req_adr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [9:0]  mem_read_adr,
  output logic [9:0]  mem_write_adr,
  output logic [63:0] mem_data_in,
  input  logic [63:0] mem_data_out,
  output logic        sq_empty
);
  localparam int PW = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [9:0]    adr_q  [SQ_DEPTH];
  logic [63:0]   data_q [SQ_DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx;
  logic [CW-1:0] count_q, count_d;
  logic          rsp_valid_q, hit_q;
  logic [63:0]   fwd_q, fwd_data;
  logic          acc, ld_acc, st_acc, drain, fwd_hit;

  assign req_ready = !rst && (count_q < CW'(SQ_DEPTH));
  assign acc       = req_valid && req_ready;
  assign ld_acc    = acc && !req_we;
  assign st_acc    = acc && req_we;
  // Any accepted request owns the memory this cycle; the head drains only when idle.
  assign drain     = !rst && (count_q != '0) && !acc;

  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (adr_q[idx] == req_adr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign mem_rd        = ld_acc && !fwd_hit;
  assign mem_read_adr  = req_adr;
  assign mem_wr        = drain;
  assign mem_write_adr = adr_q[head_q];
  assign mem_data_in   = data_q[head_q];

  always_comb begin
    count_d = count_q;
    if (st_acc && !drain)      count_d = count_q + 1'b1;
    else if (drain && !st_acc) count_d = count_q - 1'b1;
    head_d = drain  ? head_q + 1'b1 : head_q;
    tail_d = st_acc ? tail_q + 1'b1 : tail_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      rsp_valid_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      rsp_valid_q <= ld_acc;
      hit_q       <= ld_acc && fwd_hit;
    end
  end

  // Queue payload and forwarded data need no reset; validity lives in count/flags.
  always_ff @(posedge clk) begin
    if (st_acc) begin
      adr_q[tail_q]  <= req_adr;
      data_q[tail_q] <= req_wdata;
    end
    if (ld_acc && fwd_hit) fwd_q <= fwd_data;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = hit_q ? fwd_q : mem_data_out;
  assign sq_empty  = (count_q == '0);
endmodule
